// File: rtl/core_exec_dispatch.sv
// Execute-stage dispatcher. ALU/CSR results complete in the same cycle. MUL/DIV
// ops are launched, then waited on under a watchdog, and held until downstream accepts.
package core_pkg;
    typedef enum logic [2:0] {
        EXEC_ALU = 3'd0,
        EXEC_MUL = 3'd1,
        EXEC_DIV = 3'd2,
        EXEC_CSR = 3'd3,
        EXEC_RSV = 3'd4
    } exec_engine_e;
endpackage

module core_exec_dispatch #(
    parameter int WDOG_CYCLES = 63
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  core_pkg::exec_engine_e exec_engine,
    input  logic                  ex_ready,
    input  logic                  ex_flush,
    input  logic                  mul_done,
    input  logic                  div_done,
    output logic                  mul_start,
    output logic                  div_start,
    output logic                  eng_kill,
    output logic                  exec_done,
    output logic                  exec_stall,
    output logic                  exec_err
);
    import core_pkg::*;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MUL = 2'd1,
        WAIT_DIV = 2'd2,
        HOLD     = 2'd3
    } state_e;

    localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

    state_e     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;

    logic mul_start_c, div_start_c, eng_kill_c, exec_done_c, exec_err_c;
    logic wait_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign wait_done = (state_reg == WAIT_MUL) ? mul_done : div_done;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mul_start_c = 1'b0;
        div_start_c = 1'b0;
        eng_kill_c  = 1'b0;
        exec_done_c = 1'b0;
        exec_err_c  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ex_valid && !ex_flush) begin
                    case (exec_engine)
                        EXEC_ALU, EXEC_CSR, EXEC_RSV: exec_done_c = 1'b1;
                        EXEC_MUL: begin
                            mul_start_c = 1'b1;
                            cnt_next    = 8'd0;
                            state_next  = WAIT_MUL;
                        end
                        EXEC_DIV: begin
                            div_start_c = 1'b1;
                            cnt_next    = 8'd0;
                            state_next  = WAIT_DIV;
                        end
                        default: begin
                            // Illegal code: retire immediately with an error so the pipe cannot lock up.
                            exec_done_c = 1'b1;
                            exec_err_c  = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_MUL, WAIT_DIV: begin
                if (ex_flush) begin
                    eng_kill_c = 1'b1;
                    state_next = IDLE;
                end else if (wait_done) begin
                    // Completion wins over a watchdog expiring in the same cycle.
                    exec_done_c = 1'b1;
                    state_next  = ex_ready ? IDLE : HOLD;
                end else if (cnt_reg == WDOG_LAST) begin
                    exec_err_c = 1'b1;
                    eng_kill_c = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            HOLD: begin
                if (ex_flush) begin
                    state_next = IDLE;
                end else begin
                    exec_done_c = 1'b1;
                    if (ex_ready) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced low for the whole time reset is held, not just at the edge.
    assign mul_start  = rst_n & mul_start_c;
    assign div_start  = rst_n & div_start_c;
    assign eng_kill   = rst_n & eng_kill_c;
    assign exec_done  = rst_n & exec_done_c;
    assign exec_err   = rst_n & exec_err_c;
    assign exec_stall = rst_n & ex_valid & ~exec_done_c;

endmodule

// File: tb/tb_core_exec_dispatch.sv
// Directed bench for core_exec_dispatch: an IDLE decode table plus hand-built
// multi-cycle sequences (MUL/DIV completion, hold, flush, watchdog, reset).
module tb_core_exec_dispatch;
    import core_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ex_valid, ex_ready, ex_flush, mul_done, div_done;
    exec_engine_e exec_engine;
    logic         mul_start, div_start, eng_kill, exec_done, exec_stall, exec_err;

    int n_vec = 0;
    int n_bad = 0;

    core_exec_dispatch #(.WDOG_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .exec_engine(exec_engine),
        .ex_ready   (ex_ready),
        .ex_flush   (ex_flush),
        .mul_done   (mul_done),
        .div_done   (div_done),
        .mul_start  (mul_start),
        .div_start  (div_start),
        .eng_kill   (eng_kill),
        .exec_done  (exec_done),
        .exec_stall (exec_stall),
        .exec_err   (exec_err)
    );

    always #5 clk = ~clk;

    // Expected vector bit order: {mul_start, div_start, eng_kill, exec_done, exec_stall, exec_err}
    typedef struct {
        logic       v;
        logic [2:0] e;
        logic       r;
        logic       f;
        logic [5:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {mul_start, div_start, eng_kill, exec_done, exec_stall, exec_err};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (ms,ds,kill,done,stall,err)", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    // One pipeline cycle: drive at the falling edge, sample 2 ns later.
    task automatic cyc(input string name, input logic v, input logic [2:0] e, input logic r,
                       input logic f, input logic md, input logic dd, input logic [5:0] exp);
        @(negedge clk);
        ex_valid    = v;
        exec_engine = exec_engine_e'(e);
        ex_ready    = r;
        ex_flush    = f;
        mul_done    = md;
        div_done    = dd;
        #2;
        chk(name, exp);
    endtask

    localparam logic [2:0] ALU = 3'd0, MUL = 3'd1, DIV = 3'd2, CSR = 3'd3, RSV = 3'd4;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1'b0, ALU,  1'b1, 1'b0, 6'b000000};
        tbl[1]  = '{1'b1, ALU,  1'b1, 1'b0, 6'b000100};
        tbl[2]  = '{1'b1, CSR,  1'b1, 1'b0, 6'b000100};
        tbl[3]  = '{1'b1, RSV,  1'b1, 1'b0, 6'b000100};
        tbl[4]  = '{1'b1, ALU,  1'b0, 1'b0, 6'b000100};
        tbl[5]  = '{1'b1, MUL,  1'b1, 1'b0, 6'b100010};
        tbl[6]  = '{1'b1, DIV,  1'b1, 1'b0, 6'b010010};
        tbl[7]  = '{1'b1, 3'd5, 1'b1, 1'b0, 6'b000101};
        tbl[8]  = '{1'b1, 3'd7, 1'b0, 1'b0, 6'b000101};
        tbl[9]  = '{1'b1, ALU,  1'b1, 1'b1, 6'b000010};
        tbl[10] = '{1'b1, MUL,  1'b1, 1'b1, 6'b000010};
        tbl[11] = '{1'b1, 3'd6, 1'b1, 1'b1, 6'b000010};
        tbl[12] = '{1'b0, MUL,  1'b1, 1'b0, 6'b000000};
        tbl[13] = '{1'b0, 3'd7, 1'b1, 1'b0, 6'b000000};

        // Reset held with an active ALU op on the inputs: everything must stay low.
        rst_n = 1'b0;
        ex_valid = 1'b1; exec_engine = EXEC_ALU; ex_ready = 1'b1;
        ex_flush = 1'b0; mul_done = 1'b0; div_done = 1'b0;
        #3;
        chk("reset_alu", 6'b000000);
        @(negedge clk);
        exec_engine = EXEC_MUL;
        #2;
        chk("reset_mul", 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        ex_valid = 1'b0;

        // IDLE decode table; ex_valid is dropped before each rising edge so state stays IDLE.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ex_valid    = tbl[i].v;
            exec_engine = exec_engine_e'(tbl[i].e);
            ex_ready    = tbl[i].r;
            ex_flush    = tbl[i].f;
            #2;
            chk($sformatf("idle_vec%0d", i), tbl[i].exp);
            ex_valid = 1'b0;
            ex_flush = 1'b0;
        end

        // MUL, done at cycle 3, ready high.
        cyc("mul_c0",       1, MUL, 1, 0, 0, 0, 6'b100010);
        cyc("mul_c1",       1, MUL, 1, 0, 0, 0, 6'b000010);
        cyc("mul_c2",       1, MUL, 1, 0, 0, 0, 6'b000010);
        cyc("mul_c3_done",  1, MUL, 1, 0, 1, 0, 6'b000100);
        cyc("mul_c4_idle",  1, ALU, 1, 0, 1, 0, 6'b000100);

        // DIV, done at cycle 2, ready low until cycle 5 (HOLD 3..5).
        cyc("div_c0",       1, DIV, 0, 0, 1, 0, 6'b010010);
        cyc("div_c1",       1, DIV, 0, 0, 1, 0, 6'b000010);
        cyc("div_c2_done",  1, DIV, 0, 0, 1, 1, 6'b000100);
        cyc("div_c3_hold",  1, DIV, 0, 0, 1, 1, 6'b000100);
        cyc("div_c4_hold",  1, DIV, 0, 0, 1, 1, 6'b000100);
        cyc("div_c5_rdy",   1, DIV, 1, 0, 1, 1, 6'b000100);

        // New DIV (IDLE proven by the start), flushed at cycle 2, then MUL at cycle 3.
        cyc("flush_c0",     1, DIV, 1, 0, 1, 1, 6'b010010);
        cyc("flush_c1",     1, DIV, 1, 0, 1, 0, 6'b000010);
        cyc("flush_c2",     1, DIV, 1, 1, 1, 0, 6'b001010);
        // That MUL never completes: watchdog of 4 fires at cycle 4 after its start.
        cyc("wdog_c0",      1, MUL, 1, 0, 1, 0, 6'b100010);
        cyc("wdog_c1",      1, MUL, 1, 0, 0, 0, 6'b000010);
        cyc("wdog_c2",      1, MUL, 1, 0, 0, 0, 6'b000010);
        cyc("wdog_c3",      1, MUL, 1, 0, 0, 0, 6'b000010);
        cyc("wdog_c4_exp",  1, MUL, 1, 0, 0, 0, 6'b001011);
        cyc("wdog_c5_idle", 1, ALU, 1, 0, 0, 0, 6'b000100);

        // Completion in the same cycle the watchdog would expire.
        cyc("race_c0",      1, MUL, 1, 0, 0, 0, 6'b100010);
        cyc("race_c1",      1, MUL, 1, 0, 0, 0, 6'b000010);
        cyc("race_c2",      1, MUL, 1, 0, 0, 0, 6'b000010);
        cyc("race_c3",      1, MUL, 1, 0, 0, 0, 6'b000010);
        cyc("race_c4_done", 1, MUL, 1, 0, 1, 0, 6'b000100);
        cyc("race_c5_idle", 1, CSR, 1, 0, 1, 0, 6'b000100);

        // Flush in HOLD (no kill), then flush in WAIT_MUL (kill).
        cyc("hold_c0",      1, DIV, 0, 0, 1, 0, 6'b010010);
        cyc("hold_c1_done", 1, DIV, 0, 0, 1, 1, 6'b000100);
        cyc("hold_c2_fl",   1, DIV, 0, 1, 1, 1, 6'b000010);
        cyc("hold_c3_mul",  1, MUL, 1, 0, 1, 1, 6'b100010);
        cyc("wmul_flush",   1, MUL, 1, 1, 0, 1, 6'b001010);
        cyc("wmul_idle",    0, MUL, 1, 0, 0, 1, 6'b000000);

        // Asynchronous reset in WAIT_MUL with mul_done arriving.
        cyc("rst_c0",       1, MUL, 1, 0, 0, 0, 6'b100010);
        cyc("rst_c1",       1, MUL, 1, 0, 0, 0, 6'b000010);
        @(negedge clk);
        mul_done = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 6'b000000);
        @(negedge clk);
        #2;
        chk("rst_held", 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        ex_valid = 1'b0;
        mul_done = 1'b0;
        #2;
        chk("rst_release", 6'b000000);
        cyc("rst_alu",      1, ALU, 1, 0, 0, 0, 6'b000100);
        cyc("rst_mul",      1, MUL, 1, 0, 0, 0, 6'b100010);
        cyc("rst_mul_w",    1, MUL, 1, 0, 0, 0, 6'b000010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/core_exec_dispatch.md
CORE_EXEC_DISPATCH -- requirements
Module: core_exec_dispatch

Interface
REQ-001 The block SHALL have parameter WDOG_CYCLES, default 63, meaning the maximum number of cycles waited for a multi-cycle engine before abort (range 2..255).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port ex_valid  input  1  an instruction is present in the execute stage.
REQ-005 The block SHALL have port exec_engine  input  core_pkg::exec_engine_e  engine selected by the decoder: EXEC_ALU, EXEC_MUL, EXEC_DIV, EXEC_CSR or EXEC_RSV.
REQ-006 The block SHALL have port ex_ready  input  1  the downstream stage accepts the execute result this cycle.
REQ-007 The block SHALL have port ex_flush  input  1  kills the execute-stage instruction.
REQ-008 The block SHALL have port mul_done  input  1  the multiplier result is valid; held until the next mul_start.
REQ-009 The block SHALL have port div_done  input  1  the divider result is valid; held until the next div_start.
REQ-010 The block SHALL have port mul_start  output  1  one-cycle launch pulse to the multiplier.
REQ-011 The block SHALL have port div_start  output  1  one-cycle launch pulse to the divider.
REQ-012 The block SHALL have port eng_kill  output  1  one-cycle abort pulse to the active multi-cycle engine.
REQ-013 The block SHALL have port exec_done  output  1  the result selected by exec_engine is valid this cycle.
REQ-014 The block SHALL have port exec_stall  output  1  the execute stage must hold; equal to ex_valid & ~exec_done.
REQ-015 The block SHALL have port exec_err  output  1  one-cycle pulse on a watchdog timeout or an illegal engine code.

Function
REQ-016 The block SHALL implement a registered FSM with the states IDLE, WAIT_MUL, WAIT_DIV and HOLD, plus a registered 8-bit wait counter cnt.
REQ-017 In IDLE with ex_valid=1, ex_flush=0 and engine ALU, CSR or RSV, exec_done SHALL be 1 in the same cycle (zero added latency) and the state SHALL remain IDLE.
REQ-018 In IDLE with ex_valid=1, ex_flush=0 and engine MUL (or DIV), mul_start (or div_start) SHALL be 1 combinationally in that cycle, the next state SHALL be WAIT_MUL (or WAIT_DIV), cnt SHALL load 0 and exec_done SHALL be 0.
REQ-019 In IDLE with ex_valid=1 and an engine code outside the five legal values, exec_done and exec_err SHALL both be 1 for that cycle and the state SHALL remain IDLE.
REQ-020 In WAIT_x with x_done=1, exec_done SHALL be 1; the next state SHALL be IDLE if ex_ready=1, else HOLD.
REQ-021 In WAIT_x with x_done=0, cnt SHALL increment. When cnt equals WDOG_CYCLES-1, exec_err and eng_kill SHALL pulse and the next state SHALL be IDLE.
REQ-022 In HOLD, exec_done SHALL be 1 and the next state SHALL be IDLE when ex_ready=1; no start pulse SHALL be issued in HOLD.
REQ-023 ex_flush=1 SHALL take priority over every other input in every state:
  - next state IDLE, exec_done=0, no start pulse;
  - eng_kill SHALL be 1 if the current state is WAIT_MUL or WAIT_DIV.
REQ-024 Simultaneous x_done=1 and watchdog expiry SHALL count as completion: exec_done=1, no exec_err, no eng_kill.
REQ-025 A new multi-cycle instruction SHALL be launched only from IDLE, so back-to-back MUL operations have at least one cycle between start pulses; the minimum MUL/DIV latency is start cycle N, exec_done at cycle N+1.
REQ-026 The start, kill and error outputs SHALL never assert when ex_valid=0 in IDLE; at most one of mul_start and div_start SHALL be 1 in any cycle.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force state=IDLE and cnt=0.
REQ-028 While rst_n=0, the block SHALL drive mul_start, div_start, eng_kill, exec_done, exec_stall and exec_err to 0, regardless of the other inputs.
REQ-029 Reset asserted mid-operation (WAIT_x or HOLD) SHALL abandon the operation without an eng_kill pulse.
REQ-030 The first cycle after reset deassertion SHALL behave as IDLE.

Verification
REQ-031 ALU with ex_valid=1 and ex_ready=1 -> exec_done=1 in the same cycle, exec_stall=0, no start pulse.
REQ-032 MUL start at cycle 0, mul_done at cycle 3, ex_ready=1 -> mul_start only at cycle 0; exec_stall=1 for cycles 0-2; exec_done=1 at cycle 3; IDLE at cycle 4.
REQ-033 DIV with div_done at cycle 2 and ex_ready=0 until cycle 5 -> exec_done=1 for cycles 2-5, state HOLD for cycles 3-5, IDLE at cycle 6, div_start pulsed once.
REQ-034 WDOG_CYCLES=4 and a MUL that never completes -> exec_err=1 and eng_kill=1 at cycle 4 after the start, then IDLE.
REQ-035 ex_flush at cycle 2 of WAIT_DIV -> eng_kill=1 at cycle 2, exec_done=0, IDLE at cycle 3. A subsequent MUL at cycle 3 -> mul_start=1 at cycle 3.
REQ-036 rst_n low during WAIT_MUL -> all outputs 0 immediately (asynchronously). After release, an ALU op -> exec_done=1.
